// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The master side supplies operands and consumes results; the slave side is the adder.
interface cla_seq_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, Cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, Cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle wide adder: one shared 4-bit carry-lookahead slice is applied to
// successive nibbles (LSB first), with a registered carry linking the slices.

// 4-bit carry-lookahead slice. carry[i] is the carry out of bit i.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin,
  output logic [3:0] sum,
  output logic [3:0] carry
);
  logic [3:0] w_g;
  logic [3:0] w_p;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign carry[0] = w_g[0] | (w_p[0] & Cin);
  assign carry[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
  assign carry[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign carry[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign sum = w_p ^ {carry[2:0], Cin};
endmodule

module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  cla_seq_adder_if.slave    bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic            r_cr;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [IDXW+1:0] w_base;
  logic [3:0]      w_slice_a;
  logic [3:0]      w_slice_b;
  logic [3:0]      w_slice_sum;
  logic [3:0]      w_slice_carry;

  // Bit offset of the nibble currently being processed.
  assign w_base    = {r_idx, 2'b00};
  assign w_slice_a = r_opa[w_base +: 4];
  assign w_slice_b = r_opb[w_base +: 4];

  cla4 u_slice (
    .a     (w_slice_a),
    .b     (w_slice_b),
    .Cin   (r_cr),
    .sum   (w_slice_sum),
    .carry (w_slice_carry)
  );

  // Control FSM plus datapath registers; handshake outputs are registered copies of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_cr        <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opa      <= bus.a;
            r_opb      <= bus.b;
            r_cr       <= bus.Cin;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= w_slice_sum;
          r_cr               <= w_slice_carry[3];
          if (r_idx == LAST_IDX) begin
            // Final nibble: carry leaves through cout only; idx parks at 0.
            r_cout      <= w_slice_carry[3];
            r_ovf       <= w_slice_carry[3] ^ w_slice_carry[2];
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder that runs one shared 4-bit carry-lookahead slice over successive nibbles of two NIBBLES×4-bit operands, least-significant nibble first. A registered carry chains the slices. It sits between a valid/ready operand source and a valid/ready result sink. It lets wide additions reuse the team's existing 4-bit CLA slice instead of instantiating a full-width adder.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; legal range ≥1; W = 4*NIBBLES
Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  W  operand A, sampled only on accept
- b  input  W  operand B, sampled only on accept
- Cin  input  1  carry-in, sampled only on accept
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- sum  output  W  registered result, A+B+Cin mod 2^W
- cout  output  1  carry-out of the MSB
- ovf  output  1  two's-complement overflow

## Operation
- Instantiates exactly one 4-bit CLA slice: ports a[3:0], b[3:0], Cin, sum[3:0], carry[3:0]. carry[3] is the nibble carry-out; carry[2] is the carry into bit 3.
- Internal state: latched operands opa/opb (W), carry register cr, nibble counter idx (clog2(NIBBLES), min 1 bit), result register.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b and Cin into opa, opb and cr. Set idx=0 and go to RUN.
- RUN: slice inputs are opa[4*idx+:4], opb[4*idx+:4] and cr. Each cycle:
  - write slice sum into sum[4*idx+:4];
  - cr ← carry[3];
  - idx ← idx+1.
- On the RUN cycle with idx==NIBBLES-1:
  - cout ← carry[3];
  - ovf ← carry[3]^carry[2];
  - go to DONE.
- DONE: out_valid=1. sum, cout and ovf are held stable. On out_ready, return to IDLE.
- in_valid is ignored outside IDLE, and a, b, Cin may change freely while busy.
- out_ready is ignored outside DONE.
- Arithmetic: unsigned sum mod 2^W. cout equals bit W of the exact sum. ovf equals signed overflow of a+b+Cin taken as W-bit two's complement.

## Timing
- Reset (rst high at a clk edge) gives:
  - state=IDLE, in_ready=1, out_valid=0;
  - sum=0, cout=0, ovf=0;
  - idx=0, cr=0.
- rst takes priority over every other input in every state.
- Reset during RUN or DONE aborts the operation. No result is presented and the partial sum is cleared.
- Latency: accept at edge E. RUN occupies cycles E+1 … E+NIBBLES. out_valid goes high after edge E+NIBBLES, i.e. NIBBLES cycles after accept.
- Result is consumed at edge F (out_valid&&out_ready). in_ready goes high in the cycle after F; the block cannot accept in the same cycle it releases a result.
- Throughput: one operation per NIBBLES+2 cycles with no backpressure.
- in_ready and out_valid are decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- NIBBLES=1: RUN lasts one cycle and idx stays 0.
- Carry wrap-around: the final carry goes only to cout. cr never feeds the next operation, because Cin is reloaded on accept.

## Test plan
- NIBBLES=4: a=0x1234, b=0x4321, Cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready is low during RUN and DONE.
- NIBBLES=4: a=0xFFFF, b=0x0000, Cin=1 → sum=0x0000, cout=1, ovf=0 (carry ripples through all four slices). Then a=0x7FFF, b=0x0001, Cin=0 → 0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000, Cin=0 → 0x0000, cout=1, ovf=1.
- Backpressure: out_ready held low for 5 cycles in DONE → out_valid stays 1 and sum/cout/ovf stay stable. A new in_valid with different operands is ignored. After out_ready=1, in_ready=1 exactly one cycle later.
- Reset mid-operation: rst for one cycle during the second RUN cycle of 0xABCD+0x1111 → next cycle state IDLE, out_valid=0, sum=0. A following a=0x0006, b=0x0002, Cin=0 → 0x0008 with no residue from the aborted operation.
- Operand isolation: change a, b and Cin every cycle while RUN → result matches the operands sampled at the accept edge only.
- NIBBLES=1: a=6, b=2, Cin=0 → sum=8, cout=0, ovf=1. a=15, b=15, Cin=1 → sum=15, cout=1, ovf=0. a=11, b=10, Cin=1 → sum=6, cout=1, ovf=1.
